// File: rtl/training_feeder.sv
// Training-sample feeder: loads (x1, x2, t) samples into a buffer, then streams
// them to a neuron over a valid/ready handshake for a number of epochs,
// stopping early when the neuron reports done.
module training_feeder #(
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [6:0]  wr_x1,
    input  logic [6:0]  wr_x2,
    input  logic [1:0]  wr_t,
    input  logic        clear,
    input  logic        go,
    input  logic [7:0]  epochs,
    input  logic        sample_ready,
    input  logic        nm_done,
    output logic [6:0]  X1Bus,
    output logic [6:0]  X2Bus,
    output logic [1:0]  tBus,
    output logic [31:0] nBus,
    output logic        start,
    output logic        sample_valid,
    output logic        busy,
    output logic [7:0]  epoch_cnt,
    output logic        finished,
    output logic        overflow
);

    typedef enum logic [2:0] {IDLE, LAUNCH, STREAM, DRAIN, FINISH} state_t;

    state_t            state_q, state_d;
    logic [15:0]       mem_q [DEPTH];
    logic [AW:0]       count_q, count_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [7:0]        epochs_q, epochs_d;
    logic [7:0]        epoch_cnt_q, epoch_cnt_d;
    logic [6:0]        x1_q, x1_d, x2_q, x2_d;
    logic [1:0]        t_q, t_d;
    logic              overflow_q, overflow_d;
    logic              mem_we;

    // Count is one bit wider than the address, so its MSB alone flags a full buffer.
    logic              full;
    logic              last_entry;
    logic [AW-1:0]     rd_next;
    logic [15:0]       entry0;
    logic [15:0]       entry_next;
    logic [7:0]        epoch_inc;

    assign full       = count_q[AW];
    assign last_entry = ({1'b0, rd_ptr_q} == (count_q - 1'b1));
    assign rd_next    = last_entry ? '0 : rd_ptr_q + 1'b1;
    assign entry0     = mem_q[0];
    assign entry_next = mem_q[rd_next];
    assign epoch_inc  = epoch_cnt_q + 8'd1;

    // Next-state, buffer bookkeeping and output-register loading.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        epochs_d    = epochs_q;
        epoch_cnt_d = epoch_cnt_q;
        x1_d        = x1_q;
        x2_d        = x2_q;
        t_d         = t_q;
        overflow_d  = overflow_q;
        mem_we      = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear) begin
                    // Clear wins over a simultaneous write and launch.
                    count_d    = '0;
                    wr_ptr_d   = '0;
                    overflow_d = 1'b0;
                end else begin
                    if (wr_en) begin
                        if (!full) begin
                            mem_we   = 1'b1;
                            wr_ptr_d = wr_ptr_q + 1'b1;
                            count_d  = count_q + 1'b1;
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end
                    if (go && (count_q != '0)) begin
                        epochs_d    = (epochs == 8'd0) ? 8'd1 : epochs;
                        epoch_cnt_d = 8'd0;
                        rd_ptr_d    = '0;
                        state_d     = LAUNCH;
                    end
                end
            end
            LAUNCH: begin
                {x1_d, x2_d, t_d} = entry0;
                state_d           = STREAM;
            end
            STREAM: begin
                if (sample_ready) begin
                    rd_ptr_d          = rd_next;
                    {x1_d, x2_d, t_d} = entry_next;
                    if (last_entry) begin
                        epoch_cnt_d = epoch_inc;
                    end
                end
                // Early convergence beats end-of-run; the epoch update above still lands.
                if (nm_done) begin
                    state_d = FINISH;
                end else if (sample_ready && last_entry && (epoch_inc == epochs_q)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (nm_done) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            epochs_q    <= 8'd1;
            epoch_cnt_q <= 8'd0;
            x1_q        <= '0;
            x2_q        <= '0;
            t_q         <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            epochs_q    <= epochs_d;
            epoch_cnt_q <= epoch_cnt_d;
            x1_q        <= x1_d;
            x2_q        <= x2_d;
            t_q         <= t_d;
            overflow_q  <= overflow_d;
        end
    end

    // Sample storage; contents survive reset, count marks what is valid.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem_q[wr_ptr_q] <= {wr_x1, wr_x2, wr_t};
        end
    end

    assign X1Bus        = x1_q;
    assign X2Bus        = x2_q;
    assign tBus         = t_q;
    assign nBus         = {{(31 - AW){1'b0}}, count_q};
    assign start        = (state_q == LAUNCH);
    assign sample_valid = (state_q == STREAM);
    assign busy         = (state_q != IDLE);
    assign finished     = (state_q == FINISH);
    assign epoch_cnt    = epoch_cnt_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_training_feeder.sv
// Scoreboard bench for training_feeder: stimulus pushes expected beats,
// a negedge monitor pops and compares each accepted sample.
module tb_training_feeder;

    localparam int DEPTH = 512;
    localparam int AW    = 9;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [6:0]  wr_x1;
    logic [6:0]  wr_x2;
    logic [1:0]  wr_t;
    logic        clear;
    logic        go;
    logic [7:0]  epochs;
    logic        sample_ready;
    logic        nm_done;
    logic [6:0]  X1Bus;
    logic [6:0]  X2Bus;
    logic [1:0]  tBus;
    logic [31:0] nBus;
    logic        start;
    logic        sample_valid;
    logic        busy;
    logic [7:0]  epoch_cnt;
    logic        finished;
    logic        overflow;

    training_feeder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_x1(wr_x1), .wr_x2(wr_x2),
        .wr_t(wr_t), .clear(clear), .go(go), .epochs(epochs),
        .sample_ready(sample_ready), .nm_done(nm_done), .X1Bus(X1Bus),
        .X2Bus(X2Bus), .tBus(tBus), .nBus(nBus), .start(start),
        .sample_valid(sample_valid), .busy(busy), .epoch_cnt(epoch_cnt),
        .finished(finished), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_q[$];
    logic [15:0] model_mem [DEPTH];
    int          model_count = 0;
    bit          model_ovf   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted beat must match the next expected sample, and a
    // stalled sample must stay put until accepted.
    initial begin
        bit          held_v;
        logic [15:0] held_val;
        logic [15:0] cur;
        held_v = 0;
        held_val = '0;
        forever begin
            @(negedge clk);
            cur = {X1Bus, X2Bus, tBus};
            if (sample_valid === 1'b1) begin
                if (held_v) check("hold", cur, held_val);
                if (sample_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL extra_beat: got %0h expected no beat", cur);
                    end else begin
                        check("beat", cur, exp_q.pop_front());
                    end
                end
                held_v = !sample_ready;
                held_val = cur;
            end else begin
                held_v = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic reset_dut();
        rst = 1; wr_en = 0; clear = 0; go = 0; sample_ready = 0; nm_done = 0;
        wr_x1 = 0; wr_x2 = 0; wr_t = 0; epochs = 0;
        tick(); tick();
        rst = 0;
        model_count = 0;
        model_ovf = 0;
        exp_q.delete();
    endtask

    task automatic load(input logic [6:0] x1, input logic [6:0] x2, input logic [1:0] t);
        wr_en = 1; wr_x1 = x1; wr_x2 = x2; wr_t = t;
        tick();
        wr_en = 0;
        if (model_count < DEPTH) begin
            model_mem[model_count] = {x1, x2, t};
            model_count++;
        end else begin
            model_ovf = 1;
        end
    endtask

    task automatic load_rand(input int n);
        for (int i = 0; i < n; i++)
            load(7'($urandom), 7'($urandom), 2'($urandom));
    endtask

    // Full run: mode 0 = ready held high, 1 = ready toggles, 2 = random ready.
    task automatic run(input int ep, input int mode);
        int eff;
        int iters;
        eff = (ep == 0) ? 1 : ep;
        for (int e = 0; e < eff; e++)
            for (int i = 0; i < model_count; i++)
                exp_q.push_back(model_mem[i]);
        epochs = 8'(ep);
        go = 1;
        tick();
        go = 0;
        @(negedge clk);
        check("start_pulse", start, 1);
        check("start_nbus", nBus, model_count);
        tick();
        iters = 0;
        while (exp_q.size() > 0 && iters < 5000) begin
            case (mode)
                0: sample_ready = 1;
                1: sample_ready = (iters % 2 == 0);
                default: sample_ready = 1'($urandom_range(0, 1));
            endcase
            wr_en = (iters == 1);
            wr_x1 = 7'($urandom);
            go = (iters == 2);
            tick();
            iters++;
        end
        sample_ready = 0; wr_en = 0; go = 0;
        if (iters >= 5000) begin
            checks++;
            failures++;
            $display("FAIL run_timeout: got %0d beats left expected 0", exp_q.size());
            exp_q.delete();
        end
        if (mode == 0) check("consecutive_beats", iters, model_count * eff);
        @(negedge clk);
        check("drain_valid", sample_valid, 0);
        check("drain_busy", busy, 1);
        check("drain_epoch_cnt", epoch_cnt, eff);
        check("run_nbus", nBus, model_count);
        check("run_overflow", overflow, model_ovf);
        repeat (3) tick();
        check("drain_wait", busy, 1);
        check("drain_no_finish", finished, 0);
        nm_done = 1;
        tick();
        nm_done = 0;
        check("finished_pulse", finished, 1);
        tick();
        check("finished_low", finished, 0);
        check("idle_busy", busy, 0);
        check("retained_epoch_cnt", epoch_cnt, eff);
        check("retained_nbus", nBus, model_count);
    endtask

    initial begin
        reset_dut();
        tick();
        check("rst_busy", busy, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_start", start, 0);
        check("rst_finished", finished, 0);
        check("rst_nbus", nBus, 0);
        check("rst_epoch_cnt", epoch_cnt, 0);
        check("rst_bus", {X1Bus, X2Bus, tBus}, 0);
        check("rst_overflow", overflow, 0);

        // Load three samples and stream two epochs with ready held high.
        load(7'h70, 7'h70, 2'b11);
        load_rand(2);
        run(2, 0);
        // Same retained buffer under toggling backpressure.
        run(2, 1);

        // Randomized loads and runs, including epochs=0 treated as one pass.
        for (int k = 0; k < 6; k++) begin
            if (k == 3) reset_dut();
            load_rand($urandom_range(1, 6));
            run($urandom_range(0, 3), 2);
        end

        // Early convergence in pass 1 of 5.
        reset_dut();
        load_rand(4);
        for (int i = 0; i < 4; i++) exp_q.push_back(model_mem[i]);
        epochs = 8'd5;
        go = 1; tick(); go = 0;
        tick();
        sample_ready = 1;
        tick(); tick();
        sample_ready = 0; nm_done = 1;
        tick();
        nm_done = 0;
        check("early_finished", finished, 1);
        check("early_epoch_cnt", epoch_cnt, 0);
        check("early_valid", sample_valid, 0);
        check("early_beats_left", exp_q.size(), 2);
        exp_q.delete();
        tick();
        check("early_idle", busy, 0);
        check("early_finished_low", finished, 0);

        // Single-entry buffer: nm_done coincides with an end-of-pass handshake.
        reset_dut();
        load_rand(1);
        exp_q.push_back(model_mem[0]);
        epochs = 8'd5;
        go = 1; tick(); go = 0;
        tick();
        sample_ready = 1; nm_done = 1;
        tick();
        sample_ready = 0; nm_done = 0;
        check("coincide_finished", finished, 1);
        check("coincide_epoch_cnt", epoch_cnt, 1);
        check("coincide_beats_left", exp_q.size(), 0);
        tick();
        check("coincide_idle", busy, 0);

        // Reset in the middle of streaming.
        reset_dut();
        load_rand(3);
        for (int i = 0; i < 3; i++) exp_q.push_back(model_mem[i]);
        epochs = 8'd3;
        go = 1; tick(); go = 0;
        tick();
        sample_ready = 1;
        tick(); tick();
        sample_ready = 0; rst = 1;
        tick();
        rst = 0;
        exp_q.delete();
        model_count = 0;
        check("midrst_busy", busy, 0);
        check("midrst_valid", sample_valid, 0);
        check("midrst_start", start, 0);
        check("midrst_finished", finished, 0);
        check("midrst_nbus", nBus, 0);
        check("midrst_epoch_cnt", epoch_cnt, 0);
        check("midrst_bus", {X1Bus, X2Bus, tBus}, 0);

        // go with an empty buffer does nothing.
        go = 1; tick(); go = 0;
        check("emptygo_busy", busy, 0);
        check("emptygo_start", start, 0);
        tick();
        check("emptygo_busy2", busy, 0);

        // Fill past capacity, stream the full buffer once, then clear.
        load_rand(DEPTH + 1);
        check("full_nbus", nBus, DEPTH);
        check("full_overflow", overflow, 1);
        run(1, 2);
        clear = 1; wr_en = 1;
        tick();
        clear = 0; wr_en = 0;
        model_count = 0;
        model_ovf = 0;
        check("clear_nbus", nBus, 0);
        check("clear_overflow", overflow, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
